// File: rtl/ldr_avalon_slave.sv
// Avalon-MM slave that fronts a Levinson-Durbin recursion core.
// Holds the autocorrelation words R0..R[ORDER], latches the predictor words
// A0..A[ORDER], runs the start/done handshake with a timeout and a run-cycle
// counter, and raises a level interrupt when a run finishes.
//
// Bus handshake: a transfer is accepted on any clk edge where read or write is
// high (no wait states). readdata is registered, valid exactly one cycle after
// the read strobe and held until the next read. When read and write hit the
// same cycle, the read returns the value from before the write.
module ldr_avalon_slave #(
   parameter int ORDER   = 10,
   parameter int DW      = 16,
   parameter int AW      = 16,
   parameter int TIMEOUT = 4095
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AW-1:0]           address,
   input  logic                    read,
   input  logic                    write,
   input  logic [DW-1:0]           writedata,
   output logic [DW-1:0]           readdata,
   output logic                    irq,
   output logic                    core_rst_n,
   output logic                    core_start,
   output logic [(ORDER+1)*DW-1:0] core_r,
   input  logic [(ORDER+1)*DW-1:0] core_a,
   input  logic                    core_done,
   input  logic                    core_err,
   output logic [7:0]              led,
   output logic [1:0]              dbg_state
);

   localparam int NR     = ORDER + 1;
   localparam int R_BASE = 2;
   localparam int A_BASE = 3 + ORDER;

   localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
   localparam logic [AW-1:0] ADDR_STATUS = AW'(1);
   localparam logic [AW-1:0] ADDR_CYC    = AW'(4 + 2*ORDER);

   localparam logic [DW-1:0] TO_VAL = DW'(TIMEOUT);
   localparam bit            TO_EN  = (TIMEOUT != 0);

   // Sequencer states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] cycles_q, cycles_d;
   logic          soft_rst_q, soft_rst_d;
   logic          irq_en_q, irq_en_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          irq_pend_q, irq_pend_d;
   logic          timeout_q, timeout_d;
   logic          overrun_q, overrun_d;
   logic          core_start_q, core_start_d;
   logic          core_rst_n_q, core_rst_n_d;
   logic [DW-1:0] readdata_q, rd_val;
   logic [DW-1:0] r_q [NR];
   logic [DW-1:0] a_q [NR];

   logic          busy;
   logic          wr_ctrl, wr_status;
   logic          start_req;
   logic [NR-1:0] r_wr;
   logic          r_wr_any;
   logic          a_load, a_clear;
   logic          timeout_fire;
   logic [DW-1:0] status_val;

   assign busy       = (state_q != S_IDLE);
   assign wr_ctrl    = write && (address == ADDR_CTRL);
   assign wr_status  = write && (address == ADDR_STATUS);
   // A start written together with soft_rst=1 is dropped.
   assign start_req  = wr_ctrl && writedata[1] && !writedata[0];
   assign status_val = {{(DW-6){1'b0}}, overrun_q, timeout_q, irq_pend_q,
                        err_q, busy, done_q};

   // Decode which R word (if any) this write targets
   always_comb begin
      r_wr = '0;
      for (int i = 0; i < NR; i++) begin
         r_wr[i] = write && (address == AW'(R_BASE + i));
      end
   end
   assign r_wr_any = |r_wr;

   // Next-state logic for the sequencer, control and sticky status bits
   always_comb begin
      soft_rst_d   = soft_rst_q;
      irq_en_d     = irq_en_q;
      state_d      = state_q;
      cycles_d     = cycles_q;
      core_start_d = 1'b0;
      timeout_fire = 1'b0;
      a_load       = 1'b0;
      a_clear      = 1'b0;

      if (wr_ctrl) begin
         soft_rst_d = writedata[0];
         irq_en_d   = writedata[2];
      end

      // Write-1-to-clear first, so hardware set events in the same cycle win.
      done_d     = done_q     & ~(wr_status & writedata[0]);
      err_d      = err_q      & ~(wr_status & writedata[2]);
      irq_pend_d = irq_pend_q & ~(wr_status & writedata[3]);
      timeout_d  = timeout_q  & ~(wr_status & writedata[4]);
      overrun_d  = overrun_q  & ~(wr_status & writedata[5]);

      if (busy && (start_req || r_wr_any)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d      = S_ISSUE;
               core_start_d = 1'b1;
               cycles_d     = '0;
               done_d       = 1'b0;
            end
         end
         S_ISSUE: state_d = S_RUN;
         S_RUN: begin
            // core_done takes priority over a timeout landing on the same cycle.
            if (core_done) begin
               state_d = S_DONE;
               a_load  = 1'b1;
               err_d   = core_err;
            end else if (TO_EN && (cycles_q == TO_VAL)) begin
               state_d      = S_DONE;
               err_d        = 1'b1;
               timeout_d    = 1'b1;
               timeout_fire = 1'b1;
            end else if (cycles_q != '1) begin
               cycles_d = cycles_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            irq_pend_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Soft reset aborts any run and wipes results; R and irq_en survive.
      if (soft_rst_d) begin
         state_d      = S_IDLE;
         core_start_d = 1'b0;
         cycles_d     = '0;
         done_d       = 1'b0;
         err_d        = 1'b0;
         irq_pend_d   = 1'b0;
         timeout_d    = 1'b0;
         overrun_d    = 1'b0;
         a_load       = 1'b0;
         a_clear      = 1'b1;
      end

      core_rst_n_d = !soft_rst_d && !timeout_fire;
   end

   // Read mux over the register map; unmapped addresses read 0
   always_comb begin
      rd_val = '0;
      if (address == ADDR_CTRL) begin
         rd_val = {{(DW-3){1'b0}}, irq_en_q, 1'b0, soft_rst_q};
      end else if (address == ADDR_STATUS) begin
         rd_val = status_val;
      end else if (address == ADDR_CYC) begin
         rd_val = cycles_q;
      end
      for (int i = 0; i < NR; i++) begin
         if (address == AW'(R_BASE + i)) rd_val = r_q[i];
         if (address == AW'(A_BASE + i)) rd_val = a_q[i];
      end
   end

   // Control, status, sequencer and read-data registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cycles_q     <= '0;
         soft_rst_q   <= 1'b0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         irq_pend_q   <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
         core_start_q <= 1'b0;
         core_rst_n_q <= 1'b0;
         readdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cycles_q     <= cycles_d;
         soft_rst_q   <= soft_rst_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         err_q        <= err_d;
         irq_pend_q   <= irq_pend_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
         core_start_q <= core_start_d;
         core_rst_n_q <= core_rst_n_d;
         if (read) begin
            readdata_q <= rd_val;
         end
      end
   end

   // R words: bus-writable only while the sequencer is idle
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NR; i++) r_q[i] <= '0;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (r_wr[i] && !busy) r_q[i] <= writedata;
         end
      end
   end

   // A words: captured verbatim from the core on completion
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NR; i++) a_q[i] <= '0;
      end else if (a_clear) begin
         for (int i = 0; i < NR; i++) a_q[i] <= '0;
      end else if (a_load) begin
         for (int i = 0; i < NR; i++) a_q[i] <= core_a[i*DW +: DW];
      end
   end

   // Flatten R words towards the core, R0 in the LSBs
   always_comb begin
      core_r = '0;
      for (int i = 0; i < NR; i++) begin
         core_r[i*DW +: DW] = r_q[i];
      end
   end

   assign readdata   = readdata_q;
   assign irq        = irq_pend_q & irq_en_q;
   assign core_start = core_start_q;
   assign core_rst_n = core_rst_n_q;
   assign led        = {4'b0000, irq_pend_q, err_q, done_q, busy};
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ldr_avalon_slave.sv
// Self-checking bench for ldr_avalon_slave: bus reads are scored against a
// transaction-level model of the register map; a small core model answers
// start pulses with configurable latency, coefficients and error flag.
module tb_ldr_avalon_slave;

  localparam int ORDER    = 10;
  localparam int DW       = 16;
  localparam int AW       = 16;
  localparam int TO       = 48;
  localparam int NR       = ORDER + 1;
  localparam int R_BASE   = 2;
  localparam int A_BASE   = 3 + ORDER;
  localparam int CYC_ADDR = 4 + 2*ORDER;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [AW-1:0]      address;
  logic               read, write;
  logic [DW-1:0]      writedata, readdata;
  logic               irq, core_rst_n, core_start;
  logic [NR*DW-1:0]   core_r, core_a;
  logic               core_done, core_err;
  logic [7:0]         led;
  logic [1:0]         dbg_state;

  ldr_avalon_slave #(.ORDER(ORDER), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_r(core_r),
    .core_a(core_a), .core_done(core_done), .core_err(core_err),
    .led(led), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  int            start_cnt = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] r_m [NR];
  logic [DW-1:0] a_m [NR];
  logic [DW-1:0] cycles_m;
  bit st_done, st_err, st_irq, st_to, st_ov, irq_en_m;

  function automatic logic [DW-1:0] status_exp(input bit busy_m);
    logic [DW-1:0] v;
    v = '0;
    v[0] = st_done; v[1] = busy_m; v[2] = st_err;
    v[3] = st_irq;  v[4] = st_to;  v[5] = st_ov;
    return v;
  endfunction

  task automatic model_hard_reset();
    for (int i = 0; i < NR; i++) begin r_m[i] = '0; a_m[i] = '0; end
    cycles_m = '0;
    st_done = 0; st_err = 0; st_irq = 0; st_to = 0; st_ov = 0; irq_en_m = 0;
  endtask

  task automatic model_soft_reset();
    for (int i = 0; i < NR; i++) a_m[i] = '0;
    cycles_m = '0;
    st_done = 0; st_err = 0; st_irq = 0; st_to = 0; st_ov = 0;
  endtask

  // Outcome of a run: a done pulse that lands no later than the timeout cycle
  // completes normally (RUN cycles before the pulse are counted), otherwise
  // the run aborts with CYCLES at the timeout value.
  task automatic model_finish(input int d, input bit give,
                              input logic [NR*DW-1:0] a_val, input bit e);
    if (give && d <= TO + 1) begin
      for (int i = 0; i < NR; i++) a_m[i] = a_val[i*DW +: DW];
      st_err   = e;
      cycles_m = DW'(d - 1);
    end else begin
      st_err   = 1;
      st_to    = 1;
      cycles_m = DW'(TO);
    end
    st_done = 1;
    st_irq  = 1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Read monitor: one cycle after an accepted read, pop and compare
  initial begin
    forever begin
      @(posedge clk);
      if (read === 1'b1 && rst === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("unexpected_read", 32'(readdata), 32'hdead);
        end else begin
          check(name_q.pop_front(), 32'(readdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic bus_write(input int a, input logic [DW-1:0] d);
    address = AW'(a); writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input int a, input logic [DW-1:0] e, input string nm);
    address = AW'(a); read = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic write_r(input int idx, input logic [DW-1:0] v);
    bus_write(R_BASE + idx, v);
    r_m[idx] = v;
  endtask

  task automatic clr_status(input logic [DW-1:0] m);
    bus_write(1, m);
    if (m[0]) st_done = 0;
    if (m[2]) st_err  = 0;
    if (m[3]) st_irq  = 0;
    if (m[4]) st_to   = 0;
    if (m[5]) st_ov   = 0;
  endtask

  task automatic do_start();
    bus_write(0, irq_en_m ? DW'(6) : DW'(2));
    st_done = 0;
    cycles_m = '0;
  endtask

  // Core model: d cycles after the start pulse, pulse done with results.
  // Without a done pulse, watch the one-cycle core reset of the abort.
  task automatic run_core(input int d, input bit give,
                          input logic [NR*DW-1:0] a_val, input bit e);
    int i;
    i = 0;
    while (core_start !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    check("core_start_seen", 32'(core_start), 32'd1);
    if (give) begin
      repeat (d) @(negedge clk);
      core_a = a_val; core_err = e; core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0; core_err = 1'b0;
    end else begin
      repeat (TO + 2) @(negedge clk);
      check("abort_core_rst_low", 32'(core_rst_n), 32'd0);
      @(negedge clk);
      check("abort_core_rst_high", 32'(core_rst_n), 32'd1);
    end
  endtask

  task automatic check_all(input string tag);
    bus_read(1, status_exp(0), {tag, "_status"});
    bus_read(CYC_ADDR, cycles_m, {tag, "_cycles"});
    for (int i = 0; i < NR; i++) bus_read(A_BASE + i, a_m[i], {tag, "_a"});
    check({tag, "_irq"}, 32'(irq), 32'(st_irq & irq_en_m));
    check({tag, "_led"}, 32'(led), {28'd0, st_irq, st_err, st_done, 1'b0});
  endtask

  task automatic check_core_r(input string tag);
    for (int i = 0; i < NR; i++) check(tag, 32'(core_r[i*DW +: DW]), 32'(r_m[i]));
  endtask

  function automatic logic [NR*DW-1:0] rand_a();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int rvals [NR] = '{32767, 25742, 16169, 9836, 4569, -2674, -11249,
                       -17338, -14853, -6828, -3174};
    logic [NR*DW-1:0] av;
    int sc, d;
    bit g, e;

    rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    core_done = 1'b0; core_err = 1'b0; core_a = '0;
    model_hard_reset();

    // Reset
    repeat (2) @(negedge clk);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_core_rst_n", 32'(core_rst_n), 32'd1);
    for (int a = 0; a <= CYC_ADDR; a++) bus_read(a, '0, "reset_read");
    check("reset_irq", 32'(irq), 32'd0);

    // Nominal run
    for (int i = 0; i < NR; i++) write_r(i, DW'(rvals[i]));
    check_core_r("nominal_core_r");
    irq_en_m = 1;
    av = rand_a();
    av[0*DW +: DW] = DW'(4096);
    av[1*DW +: DW] = DW'(-5000);
    av[10*DW +: DW] = DW'(-123);
    sc = start_cnt;
    do_start();
    fork
      run_core(41, 1, av, 0);
      begin
        repeat (5) @(negedge clk);
        bus_read(1, status_exp(1), "run_busy");
      end
    join
    model_finish(41, 1, av, 0);
    repeat (3) @(negedge clk);
    check_all("nominal");
    check("nominal_cycles_40", 32'(cycles_m), 32'd40);
    check("nominal_starts", 32'(start_cnt - sc), 32'd1);

    // Timeout
    clr_status(DW'('h3d));
    do_start();
    run_core(0, 0, '0, 0);
    model_finish(0, 0, '0, 0);
    repeat (2) @(negedge clk);
    check_all("timeout");
    bus_read(1, DW'('h1d), "timeout_status_1d");

    // Overrun: start and R write while busy
    clr_status(DW'('h3d));
    sc = start_cnt;
    av = rand_a();
    do_start();
    fork
      run_core(30, 1, av, 0);
      begin
        repeat (5) @(negedge clk);
        bus_write(0, DW'(6));
        bus_write(R_BASE + 3, DW'(7));
        st_ov = 1;
      end
    join
    model_finish(30, 1, av, 0);
    repeat (3) @(negedge clk);
    check_all("overrun");
    check("overrun_starts", 32'(start_cnt - sc), 32'd1);
    bus_read(R_BASE + 3, r_m[3], "overrun_r3");
    clr_status(DW'('h20));
    bus_read(1, status_exp(0), "overrun_cleared");

    // Soft reset mid-run, late core_done ignored
    clr_status(DW'('h3d));
    av = rand_a();
    do_start();
    fork
      run_core(30, 1, av, 1);
      begin
        repeat (10) @(negedge clk);
        bus_write(0, DW'(5));
        model_soft_reset();
        check("soft_core_rst_low", 32'(core_rst_n), 32'd0);
      end
    join
    repeat (3) @(negedge clk);
    check_all("soft");
    bus_read(0, DW'(5), "soft_ctrl");
    for (int i = 0; i < NR; i++) bus_read(R_BASE + i, r_m[i], "soft_r_kept");
    bus_write(0, DW'(4));
    check("soft_release_core_rst", 32'(core_rst_n), 32'd1);
    av = rand_a();
    e = 1'($urandom_range(0, 1));
    do_start();
    run_core(20, 1, av, e);
    model_finish(20, 1, av, e);
    repeat (3) @(negedge clk);
    check_all("after_soft");

    // core_done on the timeout cycle: done wins
    clr_status(DW'('h3d));
    av = rand_a();
    e = 1'($urandom_range(0, 1));
    do_start();
    run_core(TO + 1, 1, av, e);
    model_finish(TO + 1, 1, av, e);
    repeat (3) @(negedge clk);
    check_all("coincident");

    // core_err reported with done
    clr_status(DW'('h3d));
    av = rand_a();
    d = $urandom_range(1, TO);
    do_start();
    run_core(d, 1, av, 1);
    model_finish(d, 1, av, 1);
    repeat (3) @(negedge clk);
    check_all("core_err");

    // Unmapped address
    bus_write(CYC_ADDR + 1, DW'($urandom));
    bus_read(CYC_ADDR + 1, '0, "unmapped_read");

    // Randomized runs
    for (int it = 0; it < 8; it++) begin
      clr_status(DW'($urandom) & DW'('h3d));
      bus_read(1, status_exp(0), "rand_w1c");
      for (int k = 0; k < 3; k++) write_r($urandom_range(0, NR - 1), DW'($urandom));
      check_core_r("rand_core_r");
      irq_en_m = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 5) != 0);
      d = $urandom_range(1, TO + 1);
      av = rand_a();
      e = 1'($urandom_range(0, 1));
      do_start();
      run_core(d, g, av, e);
      model_finish(d, g, av, e);
      repeat (3) @(negedge clk);
      check_all("rand");
    end

    // Hard reset mid-run: results gone, later done ignored
    av = rand_a();
    do_start();
    fork
      run_core(25, 1, av, 0);
      begin
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_hard_reset();
      end
    join
    repeat (3) @(negedge clk);
    check_all("hard_rst");
    for (int i = 0; i < NR; i++) bus_read(R_BASE + i, '0, "hard_rst_r");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on run time
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
